conv_stream: RTL

- Parametrised, handshaked successor to the fixed-size linear convolution engine.
- Accepts sequence A (M samples) and sequence B (N samples) over one streaming input port.
- Computes the full linear convolution Y[k] = sum_i A[i]*B[k-i], for k = 0..M+N-2, using a single time-multiplexed signed MAC.
- Streams the M+N-1 results out with backpressure. Optionally retains A, so the block can act as a reusable filter kernel.

---
 rtl/conv_stream_if.sv | 25 ++
 rtl/conv_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv_stream_if.sv
// Streaming port bundle for conv_stream: sample input with ready/valid and
// result output with ready/valid/last.
interface conv_stream_if #(
  parameter int DW = 16,
  parameter int YW = 35
);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [YW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  // slave = the convolution engine, master = the surrounding logic
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/conv_stream.sv
// Streaming linear convolution Y = A * B with one time-multiplexed signed MAC.
// A can be retained across runs so the block can act as a fixed filter kernel.
//
// state | meaning
// LOAD  | accept A (unless retained) then B samples
// MAC   | issue M products for result k, accumulate them one cycle later
// EMIT  | hold result k until downstream accepts it
module conv_stream #(
  parameter int M  = 6,
  parameter int N  = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  conv_stream_if.slave  s,
  input  logic          keep_a,
  output logic          busy
);
  localparam int YW = 2*DW + $clog2(M);
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (M + N - 1 > 1) ? $clog2(M + N - 1) : 1;
  localparam int LW = $clog2(M + N + 1);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0]           state;
  logic [LW-1:0]        ld_idx;
  logic                 a_ok;
  logic signed [DW-1:0] a_mem [M];
  logic signed [DW-1:0] b_mem [N];
  logic [KW-1:0]        k;
  logic [AW-1:0]        i;
  logic                 iss_done;
  logic                 pv;
  logic signed [YW-1:0] prod_q;
  logic signed [YW-1:0] acc;

  logic                 in_ready_q;
  logic signed [YW-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  assign s.in_ready  = in_ready_q;
  assign s.out_data  = out_data_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;

  logic                 xfer;
  logic                 load_last;
  logic                 wr_a;
  logic [AW-1:0]        wr_a_idx;
  logic [BW-1:0]        wr_b_idx;
  logic signed [YW-1:0] acc_sum;

  assign xfer      = s.in_valid && in_ready_q;
  assign load_last = a_ok ? (ld_idx == LW'(N - 1)) : (ld_idx == LW'(M + N - 1));
  assign wr_a      = !a_ok && (ld_idx < LW'(M));
  assign wr_a_idx  = AW'(ld_idx);
  assign wr_b_idx  = a_ok ? BW'(ld_idx) : BW'(ld_idx - LW'(M));
  assign acc_sum   = acc + prod_q;

  // Product issue point; the accept cycle in EMIT already issues i=0 of k+1
  // so every result costs M+1 cycles including the handshake.
  int                   iss_k;
  int                   iss_i;
  int                   bj;
  logic signed [YW-1:0] prod_n;

  always_comb begin
    iss_k  = (state == EMIT) ? int'(k) + 1 : int'(k);
    iss_i  = (state == EMIT) ? 0 : int'(i);
    bj     = iss_k - iss_i;
    prod_n = '0;
    if (bj >= 0 && bj < N) begin
      prod_n = YW'(a_mem[AW'(iss_i)]) * YW'(b_mem[BW'(bj)]);
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      if (wr_a) begin
        a_mem[wr_a_idx] <= s.in_data;
      end else begin
        b_mem[wr_b_idx] <= s.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      ld_idx      <= '0;
      a_ok        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      k           <= '0;
      i           <= '0;
      iss_done    <= 1'b0;
      pv          <= 1'b0;
      prod_q      <= '0;
      acc         <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            if (load_last) begin
              ld_idx     <= '0;
              state      <= MAC;
              k          <= '0;
              i          <= '0;
              acc        <= '0;
              pv         <= 1'b0;
              iss_done   <= 1'b0;
              in_ready_q <= 1'b0;
              busy       <= 1'b1;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        MAC: begin
          if (!iss_done) begin
            prod_q <= prod_n;
            pv     <= 1'b1;
            if (i == AW'(M - 1)) begin
              iss_done <= 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            pv <= 1'b0;
          end
          if (pv) begin
            if (iss_done) begin
              out_data_q  <= acc_sum;
              out_valid_q <= 1'b1;
              out_last_q  <= (k == KW'(M + N - 2));
              state       <= EMIT;
            end else begin
              acc <= acc_sum;
            end
          end
        end
        EMIT: begin
          if (s.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              out_last_q <= 1'b0;
              state      <= LOAD;
              in_ready_q <= 1'b1;
              busy       <= 1'b0;
              a_ok       <= keep_a;
            end else begin
              k        <= k + 1'b1;
              acc      <= '0;
              prod_q   <= prod_n;
              pv       <= 1'b1;
              i        <= (M > 1) ? AW'(1) : '0;
              iss_done <= (M == 1);
              state    <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
